// File: rtl/fixed_rrelu_pkg.sv
// Shared definitions for the fixed-point randomized leaky ReLU forward/backward blocks:
// slope mask, LFSR step, default polynomial and the saturation helper.
package fixed_rrelu_pkg;

    localparam logic [31:0] DEFAULT_LFSR_POLY = 32'h04c1_1db7;

    // Slope bits [p1-upper-1 : p1-lower] survive: slope in [0, 2^-upper) at 2^-lower resolution.
    function automatic logic [63:0] rrelu_mask(input int p1, input int upper, input int lower);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if ((i >= p1 - lower) && (i <= p1 - upper - 1)) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Left-shifting Galois step on a w-bit register; bits at and above w are don't-care.
    function automatic logic [63:0] lfsr_step(input logic [63:0] state, input logic [63:0] poly,
                                              input int w);
        logic [63:0] nxt;
        nxt = state << 1;
        if (state[w-1]) nxt = nxt ^ poly;
        return nxt;
    endfunction

    function automatic logic signed [127:0] saturate(input logic signed [127:0] v, input int w);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fixed_rrelu_backward_lane.sv
// One gradient lane: regenerates the forward slope with its own LFSR and scales the
// gradient where the forward input was negative. Clamps instead of wrapping when
// FIXED_RRELU_BACKWARD_SATURATE_EN is defined.
module fixed_rrelu_backward_lane
    import fixed_rrelu_pkg::*;
#(
    parameter int          P0        = 32,
    parameter int          P1        = 16,
    parameter int          OP0       = 32,
    parameter int          UPPER     = 1,
    parameter int          LOWER     = 6,
    parameter logic [31:0] LFSR_POLY = DEFAULT_LFSR_POLY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adv_i,
    input  logic                  seed_load_i,
    input  logic [P0-1:0]         seed_i,
    input  logic signed [P0-1:0]  grad_i,
    input  logic                  sign_i,
    output logic signed [OP0-1:0] grad_o
);
    localparam logic [P0-1:0] MASK = P0'(rrelu_mask(P1, UPPER, LOWER));
    localparam logic [P0-1:0] POLY = P0'(LFSR_POLY);

    logic [P0-1:0]          lfsr_q;
    logic [P0-1:0]          lfsr_d;
    logic [P0-1:0]          lfsr_next;
    logic signed [P0-1:0]   slope;
    logic signed [2*P0-1:0] prod;
    logic signed [2*P0-1:0] scaled;
    logic signed [2*P0-1:0] passed;
    logic signed [2*P0-1:0] sel;

    assign lfsr_next = P0'(lfsr_step(64'(lfsr_q), 64'(POLY), P0));

    // The slope for a beat is taken from the state the LFSR is about to move to,
    // matching the forward block which draws its slope the same way.
    assign slope  = MASK & lfsr_next;
    assign prod   = (2*P0)'(slope) * (2*P0)'(grad_i);
    assign scaled = prod >>> P1;
    assign passed = (2*P0)'(grad_i);
    assign sel    = sign_i ? scaled : passed;

`ifdef FIXED_RRELU_BACKWARD_SATURATE_EN
    assign grad_o = OP0'(saturate(128'(sel), OP0));
`else
    assign grad_o = OP0'(sel);
`endif

    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load_i) begin
            lfsr_d = (seed_i == '0) ? '1 : seed_i;
        end else if (adv_i) begin
            lfsr_d = lfsr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= '1;
        else     lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/fixed_rrelu_backward.sv
// Randomized leaky ReLU backward pass on a valid/ready gradient stream, one register of latency.
// Optional: define FIXED_RRELU_BACKWARD_SATURATE_EN to clamp results instead of wrapping.
module fixed_rrelu_backward
    import fixed_rrelu_pkg::*;
#(
    parameter int          DATA_IN_0_PRECISION_0       = 32,
    parameter int          DATA_IN_0_PRECISION_1       = 16,
    parameter int          DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int          DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int          DATA_OUT_0_PRECISION_0      = 32,
    parameter int          DATA_OUT_0_PRECISION_1      = 16,
    parameter int          UPPER                       = 1,
    parameter int          LOWER                       = 6,
    parameter logic [31:0] LFSR_POLY                   = DEFAULT_LFSR_POLY,
    localparam int N   = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1,
    localparam int P0  = DATA_IN_0_PRECISION_0,
    localparam int OP0 = DATA_OUT_0_PRECISION_0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [P0-1:0]  data_in_0 [N],
    input  logic [N-1:0]          sign_in_0,
    input  logic                  data_in_0_valid,
    output logic                  data_in_0_ready,
    output logic signed [OP0-1:0] data_out_0 [N],
    output logic                  data_out_0_valid,
    input  logic                  data_out_0_ready,
    input  logic                  seed_load,
    input  logic [P0-1:0]         seed_value
);
    // Output fraction must equal input fraction; a mismatched build gets an unusable shift.
    localparam int FRAC = (DATA_OUT_0_PRECISION_1 == DATA_IN_0_PRECISION_1) ?
                          DATA_IN_0_PRECISION_1 : -1;

    logic                  accept;
    logic signed [OP0-1:0] lane_grad  [N];
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic signed [OP0-1:0] out_data_q [N];
    logic signed [OP0-1:0] out_data_d [N];

    assign data_in_0_ready  = !seed_load && (!out_valid_q || data_out_0_ready);
    assign accept           = data_in_0_valid && data_in_0_ready;
    assign data_out_0_valid = out_valid_q;
    assign data_out_0       = out_data_q;

    for (genvar i = 0; i < N; i++) begin : g_lane
        fixed_rrelu_backward_lane #(
            .P0        (P0),
            .P1        (FRAC),
            .OP0       (OP0),
            .UPPER     (UPPER),
            .LOWER     (LOWER),
            .LFSR_POLY (LFSR_POLY)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .adv_i       (accept),
            .seed_load_i (seed_load),
            .seed_i      (seed_value),
            .grad_i      (data_in_0[i]),
            .sign_i      (sign_in_0[i]),
            .grad_o      (lane_grad[i])
        );
    end

    // Accepting a new beat overwrites the register even while the old one drains.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = lane_grad;
        end else if (data_out_0_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '{default: '0};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_fixed_rrelu_backward.sv
// Bench for fixed_rrelu_backward: a 4-lane 32-bit instance with a scoreboard plus a
// 16-bit-output instance for the truncation/saturation corner.
module tb_fixed_rrelu_backward;
    localparam int          NL   = 4;
    localparam logic [31:0] MASK = 32'h0000_7C00;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] NEG1 = 32'hFFFF_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic signed [31:0] din [NL];
    logic [NL-1:0]      sgn;
    logic               din_valid, din_ready;
    logic signed [31:0] dout [NL];
    logic               dout_valid, dout_ready;
    logic               seed_load;
    logic [31:0]        seed;

    logic signed [31:0] n_din [1];
    logic [0:0]         n_sgn;
    logic               n_valid, n_in_ready, n_ready;
    logic signed [15:0] n_dout [1];
    logic               n_dout_valid;

    int          total = 0;
    int          bad   = 0;
    logic [127:0] sb_q [$];
    logic [31:0]  m_state = ONES;

    fixed_rrelu_backward #(
        .DATA_IN_0_PARALLELISM_DIM_0 (NL),
        .DATA_IN_0_PARALLELISM_DIM_1 (1)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (din),
        .sign_in_0        (sgn),
        .data_in_0_valid  (din_valid),
        .data_in_0_ready  (din_ready),
        .data_out_0       (dout),
        .data_out_0_valid (dout_valid),
        .data_out_0_ready (dout_ready),
        .seed_load        (seed_load),
        .seed_value       (seed)
    );

    fixed_rrelu_backward #(
        .DATA_OUT_0_PRECISION_0 (16)
    ) u_narrow (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (n_din),
        .sign_in_0        (n_sgn),
        .data_in_0_valid  (n_valid),
        .data_in_0_ready  (n_in_ready),
        .data_out_0       (n_dout),
        .data_out_0_valid (n_dout_valid),
        .data_out_0_ready (n_ready),
        .seed_load        (1'b0),
        .seed_value       (32'h0)
    );

    function automatic logic [31:0] step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0);
    endfunction

    function automatic logic [31:0] lane_exp(input logic [31:0] slope, input logic [31:0] g,
                                             input logic s);
        longint p;
        if (!s) return g;
        p = (longint'($signed(g)) * longint'(slope)) >>> 16;
        return p[31:0];
    endfunction

    function automatic logic [15:0] narrow_exp(input logic [31:0] slope, input logic [31:0] g,
                                               input logic s);
        longint r;
        r = s ? ((longint'($signed(g)) * longint'(slope)) >>> 16) : longint'($signed(g));
`ifdef FIXED_RRELU_BACKWARD_SATURATE_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    // Scoreboard: push on input handshake, pop on output handshake, plus handshake checks.
    always @(negedge clk) begin
        logic [127:0] e, got;
        logic [31:0]  nxt;
        if (rst) begin
            m_state = ONES;
            sb_q.delete();
        end else begin
            total++;
            if (dout_valid !== (sb_q.size() != 0)) begin
                bad++;
                $display("FAIL sb_valid: got %b want %b", dout_valid, sb_q.size() != 0);
            end
            total++;
            if (din_ready !== (!seed_load && (sb_q.size() == 0 || dout_ready))) begin
                bad++;
                $display("FAIL sb_in_ready: got %b want %b", din_ready,
                         !seed_load && (sb_q.size() == 0 || dout_ready));
            end
            if (dout_valid && dout_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra_beat: got output with empty scoreboard");
                end else begin
                    e   = sb_q.pop_front();
                    got = {dout[3], dout[2], dout[1], dout[0]};
                    if (got !== e) begin
                        bad++;
                        $display("FAIL sb_data: got %h want %h", got, e);
                    end
                end
            end
            if (seed_load) begin
                m_state = (seed == 32'h0) ? ONES : seed;
            end else if (din_valid && din_ready) begin
                nxt = step(m_state);
                for (int l = 0; l < NL; l++)
                    e[l*32 +: 32] = lane_exp(nxt & MASK, din[l], sgn[l]);
                sb_q.push_back(e);
                m_state = nxt;
            end
        end
    end

    task automatic do_reset;
        rst = 1'b1; din_valid = 1'b0; seed_load = 1'b0; dout_ready = 1'b1; n_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive_all(input logic [31:0] g, input logic [NL-1:0] s);
        for (int l = 0; l < NL; l++) din[l] = g;
        sgn = s;
        din_valid = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk);
        total++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1 || n_dout_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: valid=%b in_ready=%b n_valid=%b want 0 1 0",
                     dout_valid, din_ready, n_dout_valid);
        end
        for (int l = 0; l < NL; l++) begin
            total++;
            if (dout[l] !== 32'h0) begin
                bad++;
                $display("FAIL reset_data lane%0d: got %h want 0", l, dout[l]);
            end
        end
    endtask

    task automatic test_single;
        logic [31:0] e;
        @(posedge clk); #1 drive_all(32'h0001_0000, '0);
        @(posedge clk); #1 din_valid = 1'b0;
        @(negedge clk);
        for (int l = 0; l < NL; l++) begin
            total++;
            if (dout_valid !== 1'b1 || dout[l] !== 32'h0001_0000) begin
                bad++;
                $display("FAIL single_pass lane%0d: got %b/%h want 1/00010000", l, dout_valid, dout[l]);
            end
        end
        e = -(step(step(ONES)) & MASK);
        @(posedge clk); #1 drive_all(NEG1, '1);
        @(posedge clk); #1 din_valid = 1'b0;
        @(negedge clk);
        total++;
        if (dout[0] !== e) begin
            bad++;
            $display("FAIL single_advance_once: got %h want %h", dout[0], e);
        end
    endtask

    task automatic test_sequence;
        logic [31:0] s, e;
        do_reset();
        s = ONES;
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k < 8) drive_all(NEG1, '1);
            else din_valid = 1'b0;
            @(negedge clk);
            if (k > 0) begin
                s = step(s);
                e = -(s & MASK);
                total++;
                if (dout[k % NL] !== e || ((-dout[k % NL]) & ~MASK) != 32'h0) begin
                    bad++;
                    $display("FAIL seq_slope beat%0d: got %h want %h", k - 1, dout[k % NL], e);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] sa, sb;
        logic [31:0] ea [NL];
        logic [31:0] eb [NL];
        sa = step(m_state);
        sb = step(sa);
        @(posedge clk); #1;
        dout_ready = 1'b0;
        for (int l = 0; l < NL; l++) din[l] = 32'hFFFE_0000 - l * 32'h0001_8000;
        sgn = 4'b1011; din_valid = 1'b1;
        for (int l = 0; l < NL; l++) ea[l] = lane_exp(sa & MASK, din[l], sgn[l]);
        @(posedge clk); #1;
        for (int l = 0; l < NL; l++) din[l] = 32'h0002_4000 + l * 32'h0000_1000;
        for (int l = 0; l < NL; l++) din[l] = -din[l];
        sgn = 4'b0111;
        for (int l = 0; l < NL; l++) eb[l] = lane_exp(sb & MASK, din[l], sgn[l]);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (dout_valid !== 1'b1 || din_ready !== 1'b0 || dout[c % NL] !== ea[c % NL]) begin
                bad++;
                $display("FAIL stall_hold cycle%0d: valid=%b in_ready=%b data=%h want 1 0 %h",
                         c, dout_valid, din_ready, dout[c % NL], ea[c % NL]);
            end
            @(posedge clk);
        end
        #1 dout_ready = 1'b1;
        @(posedge clk); #1 din_valid = 1'b0;
        @(negedge clk);
        for (int l = 0; l < NL; l++) begin
            total++;
            if (dout[l] !== eb[l]) begin
                bad++;
                $display("FAIL stall_resume lane%0d: got %h want %h", l, dout[l], eb[l]);
            end
        end
    endtask

    task automatic test_seed;
        logic [31:0] e;
        logic [31:0] sv [2];
        sv[0] = 32'h0; sv[1] = 32'h1234_5678;
        for (int k = 0; k < 2; k++) begin
            e = -(step((sv[k] == 32'h0) ? ONES : sv[k]) & MASK);
            @(posedge clk); #1;
            seed_load = 1'b1; seed = sv[k]; drive_all(NEG1, '1);
            @(negedge clk);
            total++;
            if (din_ready !== 1'b0) begin
                bad++;
                $display("FAIL seed_blocks_accept: in_ready=%b want 0", din_ready);
            end
            @(posedge clk); #1 seed_load = 1'b0;
            @(posedge clk); #1 din_valid = 1'b0;
            @(negedge clk);
            total++;
            if (dout[3] !== e) begin
                bad++;
                $display("FAIL seed_slope seed=%h: got %h want %h", sv[k], dout[3], e);
            end
        end
        // A pending output must survive a seed load.
        e = lane_exp(step(m_state) & MASK, 32'hFFF8_0000, 1'b1);
        @(posedge clk); #1 dout_ready = 1'b0; drive_all(32'hFFF8_0000, '1);
        @(posedge clk); #1 din_valid = 1'b0; seed_load = 1'b1; seed = 32'hCAFE_F00D;
        @(posedge clk); #1 seed_load = 1'b0;
        @(negedge clk);
        total++;
        if (dout_valid !== 1'b1 || dout[1] !== e) begin
            bad++;
            $display("FAIL seed_keeps_pending: got %b/%h want 1/%h", dout_valid, dout[1], e);
        end
        @(posedge clk); #1 dout_ready = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_midstream_reset;
        logic [31:0] e;
        e = -(step(ONES) & MASK);
        @(posedge clk); #1 dout_ready = 1'b0; drive_all(NEG1, '1);
        @(posedge clk); #1 din_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (dout_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_drops_pending: valid=%b want 0", dout_valid);
        end
        dout_ready = 1'b1;
        @(posedge clk); #1 drive_all(NEG1, '1);
        @(posedge clk); #1 din_valid = 1'b0;
        @(negedge clk);
        total++;
        if (dout[2] !== e) begin
            bad++;
            $display("FAIL reset_reseeds: got %h want %h", dout[2], e);
        end
    endtask

    task automatic test_saturate;
        logic [31:0] gv [5];
        logic        sv [5];
        logic [31:0] st;
        logic [15:0] e;
        gv[0] = 32'h7FFF_0000; sv[0] = 1'b0;
        gv[1] = 32'h8000_0000; sv[1] = 1'b0;
        gv[2] = 32'h0000_1234; sv[2] = 1'b0;
        gv[3] = 32'hFFFF_F000; sv[3] = 1'b0;
        gv[4] = 32'h7FFF_0000; sv[4] = 1'b1;
        do_reset();
        n_ready = 1'b1;
        st = ONES;
        for (int k = 0; k < 5; k++) begin
            st = step(st);
            e  = narrow_exp(st & MASK, gv[k], sv[k]);
            @(posedge clk); #1 n_din[0] = gv[k]; n_sgn = sv[k]; n_valid = 1'b1;
            @(posedge clk); #1 n_valid = 1'b0;
            @(negedge clk);
            total++;
            if (n_dout_valid !== 1'b1 || n_dout[0] !== e) begin
                bad++;
                $display("FAIL narrow_out vec%0d: got %b/%h want 1/%h", k, n_dout_valid, n_dout[0], e);
            end
        end
        total++;
`ifdef FIXED_RRELU_BACKWARD_SATURATE_EN
        e = 16'h7FFF;
`else
        e = 16'h0000;
`endif
        if (narrow_exp(ONES, gv[0], 1'b0) !== e) begin
            bad++;
            $display("FAIL narrow_model_corner: got %h want %h", narrow_exp(ONES, gv[0], 1'b0), e);
        end
    endtask

    task automatic test_random;
        int   sent = 0;
        int   cyc  = 0;
        logic acc;
        do_reset();
        while (sent < 10000 && cyc < 80000) begin
            @(negedge clk);
            acc = din_valid && din_ready;
            if (acc) sent++;
            @(posedge clk); #1;
            cyc++;
            seed_load = ($urandom_range(0, 63) == 0);
            if (seed_load) seed = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            dout_ready = ($urandom_range(0, 3) != 0);
            if (acc || !din_valid) begin
                din_valid = ($urandom_range(0, 3) != 0);
                for (int l = 0; l < NL; l++) din[l] = $urandom;
                sgn = NL'($urandom);
            end
        end
        total++;
        if (sent < 10000) begin
            bad++;
            $display("FAIL random_timeout: sent %0d want 10000", sent);
        end
        din_valid = 1'b0; seed_load = 1'b0; dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL random_lost_beats: %0d outstanding want 0", sb_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; din_valid = 1'b0; sgn = '0; dout_ready = 1'b1; seed_load = 1'b0; seed = '0;
        for (int l = 0; l < NL; l++) din[l] = '0;
        n_din[0] = '0; n_sgn = '0; n_valid = 1'b0; n_ready = 1'b1;
        test_reset();
        test_single();
        test_sequence();
        test_backpressure();
        test_seed();
        test_midstream_reset();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
